// File: rtl/cmp_sweep_ctrl.sv
// cmp_sweep_ctrl
// Steps a 2-bit comparator's operands through all 16 (a,b) pairs. Each pair
// is held for DWELL_CYCLES clocks. On the last cycle of each dwell, the
// comparator's R/G/B results are captured into the LEDs and 16-bit result logs.
//
// Ports
//   clk, rst_n          clock; synchronous active-low reset
//   start, stop         sweep start (sampled in IDLE) / abort (wins over start)
//   loop_en             restart at pair 0 after pair 15 instead of finishing
//   r_in, g_in, b_in    comparator results for the current operands
//   a_out, b_out        comparator operands (idx[3:2], idx[1:0])
//   led_r/g/b           last sampled results
//   log_r/g/b           per-pair results, bit idx = {a,b}
//   busy, done          sweeping / one-cycle completion pulse
//
// state  | meaning
// S_IDLE | waiting for start; idx and cnt held at 0
// S_DWELL| holding pair idx, counting dwell cycles, sampling on the last one
// S_DONE | one-shot sweep complete; done pulses for one cycle

module cmp_sweep_ctrl #(
    parameter int DWELL_CYCLES = 50_000_000,
    parameter int CNT_W        = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic        loop_en,
    input  logic        r_in,
    input  logic        g_in,
    input  logic        b_in,
    output logic [1:0]  a_out,
    output logic [1:0]  b_out,
    output logic        led_r,
    output logic        led_g,
    output logic        led_b,
    output logic [15:0] log_r,
    output logic [15:0] log_g,
    output logic [15:0] log_b,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DWELL = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);

    state_t            state_q, state_d;
    logic [3:0]        idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [15:0]       log_r_q, log_r_d;
    logic [15:0]       log_g_q, log_g_d;
    logic [15:0]       log_b_q, log_b_d;
    logic              led_r_q, led_r_d;
    logic              led_g_q, led_g_d;
    logic              led_b_q, led_b_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        log_r_d = log_r_q;
        log_g_d = log_g_q;
        log_b_d = log_b_q;
        led_r_d = led_r_q;
        led_g_d = led_g_q;
        led_b_d = led_b_q;

        case (state_q)
            S_IDLE: begin
                idx_d = 4'd0;
                cnt_d = '0;
                if (start && !stop) begin
                    state_d = S_DWELL;
                    log_r_d = 16'h0000;
                    log_g_d = 16'h0000;
                    log_b_d = 16'h0000;
                end
            end
            S_DWELL: begin
                if (stop) begin
                    // abort beats the sample on the same cycle; partial logs stay
                    state_d = S_IDLE;
                    idx_d   = 4'd0;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d          = '0;
                    log_r_d[idx_q] = r_in;
                    log_g_d[idx_q] = g_in;
                    log_b_d[idx_q] = b_in;
                    led_r_d        = r_in;
                    led_g_d        = g_in;
                    led_b_d        = b_in;
                    if (idx_q != 4'd15) begin
                        idx_d = idx_q + 4'd1;
                    end else if (loop_en) begin
                        idx_d = 4'd0;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                idx_d   = 4'd0;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = 4'd0;
                cnt_d   = '0;
            end
        endcase

        // busy/done are flopped from the next state so they line up with it
        busy_d = (state_d == S_DWELL);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= 4'd0;
            cnt_q   <= '0;
            log_r_q <= 16'h0000;
            log_g_q <= 16'h0000;
            log_b_q <= 16'h0000;
            led_r_q <= 1'b0;
            led_g_q <= 1'b0;
            led_b_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            log_r_q <= log_r_d;
            log_g_q <= log_g_d;
            log_b_q <= log_b_d;
            led_r_q <= led_r_d;
            led_g_q <= led_g_d;
            led_b_q <= led_b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign a_out = idx_q[3:2];
    assign b_out = idx_q[1:0];
    assign led_r = led_r_q;
    assign led_g = led_g_q;
    assign led_b = led_b_q;
    assign log_r = log_r_q;
    assign log_g = log_g_q;
    assign log_b = log_b_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_cmp_sweep_ctrl.sv
module tb_cmp_sweep_ctrl;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst_n, start, stop, loop_en;
    logic        r_in, g_in, b_in;
    logic [1:0]  a_out, b_out;
    logic        led_r, led_g, led_b;
    logic [15:0] log_r, log_g, log_b;
    logic        busy, done;

    int checks = 0;
    int errors = 0;

    localparam logic [15:0] FULL_R = 16'h7310;
    localparam logic [15:0] FULL_G = 16'h08CE;
    localparam logic [15:0] FULL_B = 16'h7BDE;

    cmp_sweep_ctrl #(.DWELL_CYCLES(D)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop_en(loop_en),
        .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .a_out(a_out), .b_out(b_out),
        .led_r(led_r), .led_g(led_g), .led_b(led_b),
        .log_r(log_r), .log_g(log_g), .log_b(log_b),
        .busy(busy), .done(done)
    );

    // comparator model
    assign r_in = (a_out > b_out);
    assign g_in = (a_out < b_out);
    assign b_in = (a_out != b_out);

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; stop = 1'b0; loop_en = 1'b0;
        tick(); tick();
        checks++;
        if ({a_out, b_out, led_r, led_g, led_b, busy, done} !== 9'b0) begin
            errors++;
            $display("FAIL reset_outs: got a=%0d b=%0d led=%b%b%b busy=%b done=%b, want all 0",
                     a_out, b_out, led_r, led_g, led_b, busy, done);
        end
        checks++;
        if ({log_r, log_g, log_b} !== 48'h0) begin
            errors++;
            $display("FAIL reset_logs: got %h %h %h, want 0", log_r, log_g, log_b);
        end
        start = 1'b0; rst_n = 1'b1;
        tick(); tick(); tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_start: busy=%b, want 0", busy);
        end
    endtask

    task automatic test_one_shot();
        logic [3:0] idx;
        int done_cnt = 0;
        loop_en = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int p = 0; p < 16; p++) begin
            for (int c = 0; c < D; c++) begin
                idx = 4'(p);
                checks++;
                if (a_out !== idx[3:2] || b_out !== idx[1:0] || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL oneshot_pair p=%0d c=%0d: got a=%0d b=%0d busy=%b, want a=%0d b=%0d busy=1",
                             p, c, a_out, b_out, busy, idx[3:2], idx[1:0]);
                end
                if (done) done_cnt++;
                if (c == 0) begin
                    checks++;
                    if (p == 0 && {log_r, log_g, log_b} !== 48'h0) begin
                        errors++;
                        $display("FAIL oneshot_clear: got %h %h %h, want 0", log_r, log_g, log_b);
                    end else if (p > 0 && {led_r, led_g, led_b} !==
                                 {FULL_R[p-1], FULL_G[p-1], FULL_B[p-1]}) begin
                        errors++;
                        $display("FAIL oneshot_led p=%0d: got %b%b%b, want %b%b%b", p - 1,
                                 led_r, led_g, led_b, FULL_R[p-1], FULL_G[p-1], FULL_B[p-1]);
                    end
                end
                tick();
            end
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || done_cnt != 0) begin
            errors++;
            $display("FAIL oneshot_done: got done=%b busy=%b early=%0d, want done=1 busy=0 early=0",
                     done, busy, done_cnt);
        end
        checks++;
        if (log_r !== FULL_R || log_g !== FULL_G || log_b !== FULL_B) begin
            errors++;
            $display("FAIL oneshot_logs: got %h %h %h, want %h %h %h",
                     log_r, log_g, log_b, FULL_R, FULL_G, FULL_B);
        end
        checks++;
        if ({led_r, led_g, led_b} !== 3'b000) begin
            errors++;
            $display("FAIL oneshot_final_led: got %b%b%b, want 000", led_r, led_g, led_b);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL oneshot_idle: got done=%b busy=%b, want 0 0", done, busy);
        end
    endtask

    task automatic test_stop();
        loop_en = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5 * D + D - 1; i++) tick();
        checks++;
        if (a_out !== 2'd1 || b_out !== 2'd1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL stop_pre: got a=%0d b=%0d busy=%b, want 1 1 1", a_out, b_out, busy);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || a_out !== 2'd0 || b_out !== 2'd0) begin
            errors++;
            $display("FAIL stop_idle: got busy=%b done=%b a=%0d b=%0d, want 0 0 0 0",
                     busy, done, a_out, b_out);
        end
        checks++;
        if (log_r !== 16'h0010 || log_g !== 16'h000E || log_b !== 16'h001E) begin
            errors++;
            $display("FAIL stop_logs: got %h %h %h, want 0010 000e 001e", log_r, log_g, log_b);
        end
        checks++;
        if ({led_r, led_g, led_b} !== 3'b101) begin
            errors++;
            $display("FAIL stop_led: got %b%b%b, want 101", led_r, led_g, led_b);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL stop_stays: got busy=%b done=%b, want 0 0", busy, done);
            end
        end
    endtask

    task automatic test_loop();
        logic [3:0] idx;
        loop_en = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int p = 0; p < 48; p++) begin
            for (int c = 0; c < D; c++) begin
                idx = 4'(p % 16);
                start = (p == 20 && c == 1);  // must be ignored mid-sweep
                if (p == 40 && c == 0) loop_en = 1'b0;
                checks++;
                if (a_out !== idx[3:2] || b_out !== idx[1:0] || busy !== 1'b1 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL loop_pair p=%0d c=%0d: got a=%0d b=%0d busy=%b done=%b, want a=%0d b=%0d busy=1 done=0",
                             p, c, a_out, b_out, busy, done, idx[3:2], idx[1:0]);
                end
                if (p >= 16 && c == 0) begin
                    checks++;
                    if (log_r !== FULL_R || log_g !== FULL_G || log_b !== FULL_B) begin
                        errors++;
                        $display("FAIL loop_logs p=%0d: got %h %h %h, want %h %h %h",
                                 p, log_r, log_g, log_b, FULL_R, FULL_G, FULL_B);
                    end
                end
                tick();
            end
        end
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL loop_done: got done=%b busy=%b, want 1 0", done, busy);
        end
        tick();
    endtask

    task automatic test_priority();
        start = 1'b1; stop = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL prio_idle: got busy=%b done=%b, want 0 0", busy, done);
            end
        end
        stop = 1'b0; start = 1'b0;
    endtask

    task automatic test_back_to_back();
        loop_en = 1'b0; start = 1'b1;
        tick();
        for (int i = 0; i < 16 * D; i++) tick();
        checks++;
        if (done !== 1'b1 || log_b !== FULL_B) begin
            errors++;
            $display("FAIL b2b_done: got done=%b log_b=%h, want 1 %h", done, log_b, FULL_B);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || log_r !== FULL_R || log_g !== FULL_G || log_b !== FULL_B) begin
            errors++;
            $display("FAIL b2b_idle: got busy=%b done=%b logs=%h %h %h, want 0 0 full logs",
                     busy, done, log_r, log_g, log_b);
        end
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || a_out !== 2'd0 || b_out !== 2'd0 || {log_r, log_g, log_b} !== 48'h0) begin
            errors++;
            $display("FAIL b2b_restart: got busy=%b a=%0d b=%0d logs=%h %h %h, want 1 0 0 cleared",
                     busy, a_out, b_out, log_r, log_g, log_b);
        end
    endtask

    task automatic test_reset_mid();
        // continues the sweep begun by test_back_to_back
        for (int i = 0; i < 9 * D + 1; i++) tick();
        checks++;
        if (a_out !== 2'd2 || b_out !== 2'd1 || log_b !== 16'h01DE || busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre: got a=%0d b=%0d log_b=%h busy=%b, want 2 1 01de 1",
                     a_out, b_out, log_b, busy);
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if ({a_out, b_out, led_r, led_g, led_b, busy, done} !== 9'b0 ||
            {log_r, log_g, log_b} !== 48'h0) begin
            errors++;
            $display("FAIL mid_reset: got a=%0d b=%0d led=%b%b%b busy=%b done=%b logs=%h %h %h, want all 0",
                     a_out, b_out, led_r, led_g, led_b, busy, done, log_r, log_g, log_b);
        end
        rst_n = 1'b1;
        tick(); tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_after: busy=%b, want 0", busy);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
        #2;
        test_reset();
        test_one_shot();
        test_stop();
        test_loop();
        test_priority();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
